// File: rtl/output_forward.sv
// Forward-pass output neuron: holds the output-layer weight bank and serially
// multiply-accumulates hidden values into a saturating 23-bit pre-activation.
module output_forward #(
    parameter int N_HIDDEN = 4,
    parameter int AW       = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          hid_valid_i,
    input  logic [9:0]    hidden_val_i,
    input  logic          w_wr_i,
    input  logic [AW-1:0] w_addr_i,
    input  logic [7:0]    w_i,
    input  logic          zero_weight_reset_i,
    output logic [22:0]   final_o,
    output logic          busy_o,
    output logic          f_end_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [22:0] SAT_MAX = 23'h7FFFFF;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [22:0]   acc_q, acc_d;
    logic [22:0]   final_q, final_d;
    logic          busy_q, busy_d;
    logic          f_end_q, f_end_d;

    logic [7:0]    w_q [N_HIDDEN];
    logic [7:0]    w_d [N_HIDDEN];
    logic [N_HIDDEN-1:0] w_sel;

    logic [7:0]    w_rd;
    logic [17:0]   prod;
    logic [23:0]   sum;
    logic [22:0]   acc_sat;
    logic          last_beat;

    // Per-entry write decode; addresses at or beyond N_HIDDEN match no entry
    // and are therefore dropped.
    generate
        for (genvar gi = 0; gi < N_HIDDEN; gi++) begin : g_wsel
            assign w_sel[gi] = w_wr_i && (w_addr_i == AW'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N_HIDDEN; i++) begin
            w_d[i] = w_q[i];
            if (zero_weight_reset_i) begin
                w_d[i] = 8'd0;
            end else if (w_sel[i]) begin
                w_d[i] = w_i;
            end
        end
    end

    // The MAC reads the registered bank, so a same-cycle write is seen next cycle.
    always_comb begin
        w_rd      = w_q[idx_q];
        prod      = 18'(hidden_val_i) * 18'(w_rd);
        sum       = {1'b0, acc_q} + {6'd0, prod};
        acc_sat   = sum[23] ? SAT_MAX : sum[22:0];
        last_beat = (idx_q == AW'(N_HIDDEN - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        final_d = final_q;
        busy_d  = busy_q;
        f_end_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ACCUM: begin
                if (hid_valid_i) begin
                    acc_d = acc_sat;
                    idx_d = idx_q + 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                        final_d = acc_sat;
                        busy_d  = 1'b0;
                        f_end_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            final_q <= '0;
            busy_q  <= 1'b0;
            f_end_q <= 1'b0;
            for (int i = 0; i < N_HIDDEN; i++) begin
                w_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            final_q <= final_d;
            busy_q  <= busy_d;
            f_end_q <= f_end_d;
            for (int i = 0; i < N_HIDDEN; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign final_o = final_q;
    assign busy_o  = busy_q;
    assign f_end_o = f_end_q;

endmodule
